xpi_nor_model: RTL and testbench
================================

# xpi_nor_model

Clock-oversampled serial NOR flash target model: the parametrised successor to the team's fixed 2-2-2 and 4-4-4 behavioural flash models. It samples `sck`/`csb`/`dio` synchronously on the system clock, selects 1-1-1, 2-2-2 or 4-4-4 lane mode at run time, and serves reads from a preloadable byte array. It sits on the NOR pins beside the flash controller in simulation and FPGA loopback rigs, replacing per-mode `csb` gating with a single instance.

## Interface
Parameters:
- `DEPTH_LOG2`, 9: array holds 2^DEPTH_LOG2 bytes; the address wraps modulo this size.
- `DUMMY_1`, 8: dummy `sck` cycles for 0x0B in 1-1-1 mode.
- `DUMMY_2`, 8: dummy `sck` cycles for 0x0B in 2-2-2 mode.
- `DUMMY_4`, 10: dummy `sck` cycles for 0x0B in 4-4-4 mode.
- `SYNC_STAGES`, 2: synchroniser depth on `sck` and `csb` (≥2).

Ports (one clock `clk`; reset `rstn` is asynchronous, active-low):
- `clk` in 1: system clock; all state updates on its rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `sck` in 1: serial clock from the flash controller.
- `csb` in 1: chip select, active-low.
- `dio_i` in 4: pad input lanes.
- `dio_o` out 4: pad output lanes.
- `dio_oe` out 4: per-lane output enable; the pad drives `dio_o` when set.
- `mode` in 2: lane mode. 0 = 1-1-1, 1 = 2-2-2, 2 = 4-4-4, 3 = reserved. Latched at `csb` fall.
- `init_we` in 1: preload write strobe. Accepted only in IDLE.
- `init_addr` in DEPTH_LOG2: preload address.
- `init_data` in 8: preload data.
- `busy` out 1: high in any state except IDLE.
- `cmd_err` out 1: one-`clk` pulse when a command is rejected.

## Operation
- Edge detection:
  - `sck` and `csb` pass through SYNC_STAGES flops. `dio_i` is delayed to match.
  - Edges are found by comparing the last two synchronised samples.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- IDLE:
  - Synchronised `csb` fall latches `mode`, clears the shift counter and moves to CMD.
  - A latched mode of 3 goes straight to IGNORE and pulses `cmd_err`.
- Lanes per `sck` edge, by mode:
  - 1-1-1: input on `dio_i[0]`, output on `dio_o[1]`.
  - 2-2-2: lanes [1:0].
  - 4-4-4: lanes [3:0].
- Bit order: MSB first; each `sck` rising edge shifts in one lane-group.
- CMD: after 8 bits, decode the command byte.
  - 0x03: go to ADDR with zero dummy cycles.
  - 0x0B: go to ADDR with the mode's DUMMY_n cycles.
  - Anything else: go to IGNORE and pulse `cmd_err`.
- ADDR: shift 24 address bits. Only the low DEPTH_LOG2 bits are kept. Then go to DUMMY, or to DATA if the dummy count is 0.
- DUMMY: count `sck` rising edges; at DUMMY_n, go to DATA.
- DATA:
  - On each `sck` falling edge, drive the next lane-group of `array[addr]` and set the active lanes' `dio_oe`.
  - After the last group of a byte, `addr` increments and wraps from 2^DEPTH_LOG2−1 to 0.
  - Reads continue until `csb` rises.
- IGNORE: `dio_oe` stays 0; all `sck` activity is ignored.
- `csb` rise (synchronised) in any state: `dio_oe` = 0 and go to IDLE on the same `clk`; a partial byte is discarded.
- `init_we` outside IDLE is dropped; the array is unchanged.
- The array is not reset; its contents survive `rstn`.

## Timing
- Reset values:
  - `dio_o` = 0, `dio_oe` = 0, `busy` = 0, `cmd_err` = 0, state = IDLE.
  - Counters and the address register = 0.
- Reset mid-transaction: outputs drop within the same `clk` (asynchronous); the next transaction needs a fresh `csb` fall.
- `sck` high and low phases must each be ≥ SYNC_STAGES+1 `clk` periods; faster `sck` is unsupported.
- Latencies:
  - `sck` fall to `dio_o`/`dio_oe` update: SYNC_STAGES+1 `clk`.
  - `csb` rise to `dio_oe` = 0: SYNC_STAGES+1 `clk`.
- First data lane-group: driven on the first `sck` fall after the last address or dummy rising edge.
- `init_we` writes take effect on the next `clk`. A read in the same cycle as a write to the same address returns the old byte.

## Configuration
- `XPINOR_WRITE_EN` defined: command 0x02 (page program) is supported.
  - Flow: ADDR, then a receive state that shifts data on `sck` rising edges; each completed byte writes `array[addr]` and `addr` increments with wrap. `dio_oe` stays 0.
  - A partial byte at `csb` rise is discarded.
- `XPINOR_WRITE_EN` undefined: 0x02 is rejected like any unsupported command (IGNORE, `cmd_err` pulse).

## Test plan
- Preload `array[0x000..0x003]` = 11 22 33 44; mode 0; send 0x0B, addr 0x000000, 8 dummy cycles, 32 clocks → `dio_o[1]` yields 11 22 33 44, `dio_oe` = 4'b0010.
- Mode 2; send 0x0B, addr 0x0001FF, 10 dummy cycles, read 2 bytes → `array[0x1FF]` then `array[0x000]` (wrap), `dio_oe` = 4'hF.
- Mode 1; send 0x03, addr 0x000010; raise `csb` after 3 `sck` falls → `dio_oe` = 0 within SYNC_STAGES+1 `clk`, `busy` = 0.
- Mode 0; send command 0x9F → exactly one `cmd_err` pulse, `dio_oe` stays 0 for the rest of the transaction; the next 0x03 read succeeds.
- Drop `rstn` mid-DATA in mode 2 → all outputs 0 immediately; preloaded array contents are intact on the next read.
- With `XPINOR_WRITE_EN`: mode 2, 0x02 at addr 0x000020 with data AA BB, then 0x03 read at 0x000020 → AA BB. Without the macro: `cmd_err` pulses and the read returns the preload values.

Source files
------------

// File: rtl/xpi_nor_model.sv
// xpi_nor_model: clock-oversampled serial NOR flash target serving 1-1-1 / 2-2-2 / 4-4-4 reads.
// Optional feature: define XPINOR_WRITE_EN to support page program (command 0x02).
module xpi_nor_model #(
   parameter int DEPTH_LOG2  = 9,
   parameter int DUMMY_1     = 8,
   parameter int DUMMY_2     = 8,
   parameter int DUMMY_4     = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  sck,
   input  logic                  csb,
   input  logic [3:0]            dio_i,
   output logic [3:0]            dio_o,
   output logic [3:0]            dio_oe,
   input  logic [1:0]            mode,
   input  logic                  init_we,
   input  logic [DEPTH_LOG2-1:0] init_addr,
   input  logic [7:0]            init_data,
   output logic                  busy,
   output logic                  cmd_err
);
   localparam int SH_W = (DEPTH_LOG2 > 8) ? DEPTH_LOG2 : 8;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE, ST_RECV
   } state_t;

   function automatic logic [4:0] lane_w(input logic [1:0] m);
      case (m)
         2'd0:    lane_w = 5'd1;
         2'd1:    lane_w = 5'd2;
         default: lane_w = 5'd4;
      endcase
   endfunction

   function automatic logic [3:0] lane_oe(input logic [1:0] m);
      case (m)
         2'd0:    lane_oe = 4'b0010;
         2'd1:    lane_oe = 4'b0011;
         default: lane_oe = 4'b1111;
      endcase
   endfunction

   // b holds the remaining bits of the byte, next-to-send in b[3]
   function automatic logic [3:0] lane_out(input logic [1:0] m, input logic [3:0] b);
      case (m)
         2'd0:    lane_out = {2'b00, b[3], 1'b0};
         2'd1:    lane_out = {2'b00, b[3:2]};
         default: lane_out = b;
      endcase
   endfunction

   function automatic logic [SH_W-1:0] shift_in(input logic [1:0] m, input logic [SH_W-1:0] sh,
                                                input logic [3:0] d);
      case (m)
         2'd0:    shift_in = SH_W'({sh, d[0]});
         2'd1:    shift_in = SH_W'({sh, d[1:0]});
         default: shift_in = SH_W'({sh, d});
      endcase
   endfunction

   function automatic logic [7:0] dummy_for(input logic [1:0] m);
      case (m)
         2'd0:    dummy_for = 8'(DUMMY_1);
         2'd1:    dummy_for = 8'(DUMMY_2);
         default: dummy_for = 8'(DUMMY_4);
      endcase
   endfunction

   logic [SYNC_STAGES:0]  sck_sh_r, csb_sh_r;
   logic [3:0]            dio_sh_r [SYNC_STAGES];
   logic [7:0]            mem_r [2**DEPTH_LOG2];
   state_t                state_r;
   logic [1:0]            mode_r;
   logic [4:0]            cnt_r;
   logic [7:0]            dcnt_r, dtgt_r;
   logic [DEPTH_LOG2-1:0] addr_r;
   logic [SH_W-1:0]       sh_r;
   logic [3:0]            dio_o_r, dio_oe_r;
   logic                  busy_r, cmd_err_r;
`ifdef XPINOR_WRITE_EN
   logic                  wr_r;
   logic                  prog_we_s;
`endif

   logic                  sck_rise_s, sck_fall_s, csb_rise_s, csb_fall_s;
   logic [4:0]            cnt_nxt_s;
   logic [SH_W-1:0]       sh_nxt_s;
   logic [3:0]            rd_top_s;
   logic                  mem_we_s;
   logic [DEPTH_LOG2-1:0] mem_waddr_s;
   logic [7:0]            mem_wdata_s;

   // synchronise sck/csb and delay dio_i by the same number of stages
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sck_sh_r <= {(SYNC_STAGES+1){1'b0}};
         csb_sh_r <= {(SYNC_STAGES+1){1'b1}};
         for (int i = 0; i < SYNC_STAGES; i++) dio_sh_r[i] <= 4'h0;
      end else begin
         sck_sh_r    <= {sck_sh_r[SYNC_STAGES-1:0], sck};
         csb_sh_r    <= {csb_sh_r[SYNC_STAGES-1:0], csb};
         dio_sh_r[0] <= dio_i;
         for (int i = 1; i < SYNC_STAGES; i++) dio_sh_r[i] <= dio_sh_r[i-1];
      end
   end

   assign sck_rise_s =  sck_sh_r[SYNC_STAGES-1] & ~sck_sh_r[SYNC_STAGES];
   assign sck_fall_s = ~sck_sh_r[SYNC_STAGES-1] &  sck_sh_r[SYNC_STAGES];
   assign csb_rise_s =  csb_sh_r[SYNC_STAGES-1] & ~csb_sh_r[SYNC_STAGES];
   assign csb_fall_s = ~csb_sh_r[SYNC_STAGES-1] &  csb_sh_r[SYNC_STAGES];
   assign cnt_nxt_s  = cnt_r + lane_w(mode_r);
   assign sh_nxt_s   = shift_in(mode_r, sh_r, dio_sh_r[SYNC_STAGES-1]);
   assign rd_top_s   = 4'((mem_r[addr_r] << cnt_r) >> 3'd4);
`ifdef XPINOR_WRITE_EN
   assign prog_we_s  = (state_r == ST_RECV) && sck_rise_s && !csb_rise_s && (cnt_nxt_s == 5'd8);
`endif

   // array write port: preload in IDLE, page program while receiving
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = init_addr;
      mem_wdata_s = init_data;
      if ((state_r == ST_IDLE) && init_we) begin
         mem_we_s = 1'b1;
`ifdef XPINOR_WRITE_EN
      end else if (prog_we_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = addr_r;
         mem_wdata_s = sh_nxt_s[7:0];
`endif
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // byte array storage; deliberately not reset so preloads survive rstn
   always_ff @(posedge clk) begin
      if (mem_we_s) mem_r[mem_waddr_s] <= mem_wdata_s;
   end

   // protocol FSM with registered pad and status outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         mode_r    <= 2'd0;
         cnt_r     <= 5'd0;
         dcnt_r    <= 8'd0;
         dtgt_r    <= 8'd0;
         addr_r    <= {DEPTH_LOG2{1'b0}};
         sh_r      <= {SH_W{1'b0}};
         dio_o_r   <= 4'h0;
         dio_oe_r  <= 4'h0;
         busy_r    <= 1'b0;
         cmd_err_r <= 1'b0;
`ifdef XPINOR_WRITE_EN
         wr_r      <= 1'b0;
`endif
      end else begin
         cmd_err_r <= 1'b0;
         if (csb_rise_s) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            dio_o_r  <= 4'h0;
            dio_oe_r <= 4'h0;
            cnt_r    <= 5'd0;
         end else begin
            case (state_r)
               ST_IDLE: if (csb_fall_s) begin
                  mode_r <= mode;
                  cnt_r  <= 5'd0;
                  dcnt_r <= 8'd0;
                  busy_r <= 1'b1;
                  if (mode == 2'd3) begin
                     state_r   <= ST_IGNORE;
                     cmd_err_r <= 1'b1;
                  end else begin
                     state_r <= ST_CMD;
                  end
               end
               ST_CMD: if (sck_rise_s) begin
                  sh_r <= sh_nxt_s;
                  if (cnt_nxt_s == 5'd8) begin
                     cnt_r <= 5'd0;
                     case (sh_nxt_s[7:0])
                        8'h03: begin state_r <= ST_ADDR; dtgt_r <= 8'd0; end
                        8'h0B: begin state_r <= ST_ADDR; dtgt_r <= dummy_for(mode_r); end
`ifdef XPINOR_WRITE_EN
                        8'h02: begin state_r <= ST_ADDR; dtgt_r <= 8'd0; wr_r <= 1'b1; end
`endif
                        default: begin state_r <= ST_IGNORE; cmd_err_r <= 1'b1; end
                     endcase
                  end else begin
                     cnt_r <= cnt_nxt_s;
                  end
               end
               ST_ADDR: if (sck_rise_s) begin
                  sh_r <= sh_nxt_s;
                  if (cnt_nxt_s == 5'd24) begin
                     cnt_r  <= 5'd0;
                     dcnt_r <= 8'd0;
                     addr_r <= sh_nxt_s[DEPTH_LOG2-1:0];
`ifdef XPINOR_WRITE_EN
                     if (wr_r) state_r <= ST_RECV;
                     else
`endif
                     if (dtgt_r == 8'd0) state_r <= ST_DATA;
                     else state_r <= ST_DUMMY;
                  end else begin
                     cnt_r <= cnt_nxt_s;
                  end
               end
               ST_DUMMY: if (sck_rise_s) begin
                  if (dcnt_r + 8'd1 == dtgt_r) state_r <= ST_DATA;
                  else dcnt_r <= dcnt_r + 8'd1;
               end
               ST_DATA: if (sck_fall_s) begin
                  dio_o_r  <= lane_out(mode_r, rd_top_s);
                  dio_oe_r <= lane_oe(mode_r);
                  if (cnt_nxt_s == 5'd8) begin
                     cnt_r  <= 5'd0;
                     addr_r <= addr_r + DEPTH_LOG2'(1);
                  end else begin
                     cnt_r <= cnt_nxt_s;
                  end
               end
`ifdef XPINOR_WRITE_EN
               ST_RECV: if (sck_rise_s) begin
                  sh_r <= sh_nxt_s;
                  if (cnt_nxt_s == 5'd8) begin
                     cnt_r  <= 5'd0;
                     addr_r <= addr_r + DEPTH_LOG2'(1);
                  end else begin
                     cnt_r <= cnt_nxt_s;
                  end
               end
`endif
               ST_IGNORE: dio_oe_r <= 4'h0;
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

   assign dio_o   = dio_o_r;
   assign dio_oe  = dio_oe_r;
   assign busy    = busy_r;
   assign cmd_err = cmd_err_r;
endmodule

// File: tb/tb_xpi_nor_model.sv
// Randomised scoreboard bench for xpi_nor_model: stimulus pushes expected read bytes,
// a pin-level monitor rebuilds bytes at each controller sampling edge and compares.
module tb_xpi_nor_model;
   localparam int DL = 9;
   localparam int H  = 5;

   logic          clk = 1'b0, rstn = 1'b0, sck = 1'b0, csb = 1'b1;
   logic [3:0]    dio_i = 4'h0;
   logic [3:0]    dio_o, dio_oe;
   logic [1:0]    mode = 2'd0;
   logic          init_we = 1'b0;
   logic [DL-1:0] init_addr = '0;
   logic [7:0]    init_data = 8'h00;
   logic          busy, cmd_err;

   int         errors = 0, checks = 0;
   logic [7:0] ref_mem [0:(1<<DL)-1];
   logic [7:0] sb_q [$];
   int         cur_w = 1;
   logic [3:0] cur_oe = 4'b0010;
   int         err_pulses = 0;
   bit         oe_seen = 1'b0;
   int         acc_n = 0;
   logic [7:0] acc = 8'h00;

   xpi_nor_model dut (
      .clk(clk), .rstn(rstn), .sck(sck), .csb(csb), .dio_i(dio_i), .dio_o(dio_o),
      .dio_oe(dio_oe), .mode(mode), .init_we(init_we), .init_addr(init_addr),
      .init_data(init_data), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int lw(input int m);
      return (m == 0) ? 1 : (m == 1) ? 2 : 4;
   endfunction

   function automatic logic [3:0] oe_of(input int m);
      return (m == 0) ? 4'b0010 : (m == 1) ? 4'b0011 : 4'b1111;
   endfunction

   function automatic int dummy_of(input int m);
      return (m == 0) ? 8 : (m == 1) ? 8 : 10;
   endfunction

   always @(negedge clk) begin
      if (cmd_err === 1'b1) err_pulses++;
      if (dio_oe !== 4'h0) oe_seen = 1'b1;
   end

   // monitor: controller samples the pads on each sck rise while the target drives
   always @(posedge sck or posedge csb or negedge rstn) begin
      if (csb || !rstn) begin
         acc_n = 0;
      end else if (dio_oe != 4'h0) begin
         check("mon_oe", {28'h0, dio_oe}, {28'h0, cur_oe});
         if (cur_w == 1)      acc = {acc[6:0], dio_o[1]};
         else if (cur_w == 2) acc = {acc[5:0], dio_o[1:0]};
         else                 acc = {acc[3:0], dio_o};
         acc_n += cur_w;
         if (acc_n >= 8) begin
            acc_n = 0;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mon_unexpected: got byte %0h expected none", acc);
            end else begin
               check("mon_byte", {24'h0, acc}, {24'h0, sb_q.pop_front()});
            end
         end
      end
   end

   task automatic sck_cycle(input logic [3:0] d);
      dio_i = d;
      repeat (H) @(negedge clk);
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic send_bits(input int m, input logic [23:0] val, input int nbits);
      int w;
      logic [3:0] mask, g;
      w = lw(m);
      mask = 4'((1 << w) - 1);
      for (int i = 0; i < nbits / w; i++) begin
         g = 4'(val >> (nbits - w * (i + 1))) & mask;
         sck_cycle((4'($urandom) & ~mask) | g);
      end
   endtask

   task automatic begin_cs(input int m);
      mode = 2'(m);
      csb = 1'b0;
      repeat (H) @(negedge clk);
      mode = 2'($urandom);
   endtask

   task automatic end_cs();
      repeat (H) @(negedge clk);
      csb = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   task automatic init_write(input logic [DL-1:0] a, input logic [7:0] d);
      init_we = 1'b1; init_addr = a; init_data = d;
      @(negedge clk);
      init_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic drop_write(input logic [DL-1:0] a);
      init_we = 1'b1; init_addr = a; init_data = ~ref_mem[a];
      @(negedge clk);
      init_we = 1'b0;
   endtask

   task automatic read_txn(input int m, input logic [7:0] cmd, input logic [23:0] a, input int n);
      int w, nd;
      logic [DL-1:0] ai;
      w = lw(m);
      nd = (cmd == 8'h0B) ? dummy_of(m) : 0;
      cur_w = w;
      cur_oe = oe_of(m);
      begin_cs(m);
      check("busy_hi", {31'h0, busy}, 32'h1);
      send_bits(m, 24'(cmd), 8);
      send_bits(m, a, 24);
      repeat (nd) sck_cycle(4'($urandom));
      for (int i = 0; i < n; i++) begin
         ai = a[DL-1:0] + DL'(i);
         sb_q.push_back(ref_mem[ai]);
      end
      repeat (n * 8 / w) sck_cycle(4'($urandom));
      drop_write(a[DL-1:0]);
      end_cs();
      check("busy_lo", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      logic [23:0] a;
      repeat (3) @(negedge clk);
      check("rst_dio_o", {28'h0, dio_o}, 32'h0);
      check("rst_dio_oe", {28'h0, dio_oe}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_cmd_err", {31'h0, cmd_err}, 32'h0);
      rstn = 1'b1;
      @(negedge clk);
      for (int i = 0; i < (1 << DL); i++) init_write(DL'(i), 8'($urandom));
      init_write(9'h000, 8'h11);
      init_write(9'h001, 8'h22);
      init_write(9'h002, 8'h33);
      init_write(9'h003, 8'h44);

      read_txn(0, 8'h0B, 24'h000000, 4);
      read_txn(2, 8'h0B, 24'h0001FF, 2);

      // early csb rise mid-byte in 2-2-2
      cur_w = 2; cur_oe = 4'b0011;
      begin_cs(1);
      send_bits(1, 24'h000003, 8);
      send_bits(1, 24'h000010, 24);
      repeat (2) sck_cycle(4'($urandom));
      repeat (4) @(negedge clk);
      check("part_oe_on", {28'h0, dio_oe}, 32'h3);
      csb = 1'b1;
      repeat (2) @(negedge clk);
      check("part_oe_hold", {28'h0, dio_oe}, 32'h3);
      @(negedge clk);
      check("part_oe_off", {28'h0, dio_oe}, 32'h0);
      check("part_busy", {31'h0, busy}, 32'h0);
      repeat (2 * H) @(negedge clk);

      // unsupported command, then a good read
      p0 = err_pulses; oe_seen = 1'b0;
      begin_cs(0);
      send_bits(0, 24'h00009F, 8);
      send_bits(0, 24'($urandom), 24);
      repeat (8) sck_cycle(4'($urandom));
      end_cs();
      check("bad_cmd_pulse", 32'(err_pulses - p0), 32'h1);
      check("bad_cmd_oe", {31'h0, oe_seen}, 32'h0);
      read_txn(0, 8'h03, 24'h000004, 2);

      // reserved mode
      p0 = err_pulses; oe_seen = 1'b0;
      begin_cs(3);
      send_bits(2, 24'h00000B, 8);
      end_cs();
      check("mode3_pulse", 32'(err_pulses - p0), 32'h1);
      check("mode3_oe", {31'h0, oe_seen}, 32'h0);

      // reset in the middle of a 4-4-4 read
      a = 24'($urandom);
      cur_w = 4; cur_oe = 4'hF;
      begin_cs(2);
      send_bits(2, 24'h000003, 8);
      send_bits(2, a, 24);
      sb_q.push_back(ref_mem[a[DL-1:0]]);
      repeat (3) sck_cycle(4'($urandom));
      repeat (4) @(negedge clk);
      check("mid_oe_on", {28'h0, dio_oe}, 32'hF);
      rstn = 1'b0;
      #1;
      check("mid_rst_oe", {28'h0, dio_oe}, 32'h0);
      check("mid_rst_o", {28'h0, dio_o}, 32'h0);
      check("mid_rst_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      csb = 1'b1;
      repeat (4) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      read_txn(2, 8'h0B, a, 2);

      // page program (or its rejection)
      p0 = err_pulses; oe_seen = 1'b0;
      begin_cs(2);
      send_bits(2, 24'h000002, 8);
      send_bits(2, 24'h000020, 24);
      send_bits(2, 24'h0000AA, 8);
      send_bits(2, 24'h0000BB, 8);
      end_cs();
      check("prog_oe", {31'h0, oe_seen}, 32'h0);
`ifdef XPINOR_WRITE_EN
      ref_mem[9'h020] = 8'hAA;
      ref_mem[9'h021] = 8'hBB;
      check("prog_no_err", 32'(err_pulses - p0), 32'h0);
`else
      check("prog_rej_pulse", 32'(err_pulses - p0), 32'h1);
`endif
      read_txn(2, 8'h03, 24'h000020, 2);

      for (int t = 0; t < 16; t++) begin
         a = 24'($urandom);
         read_txn($urandom_range(0, 2), ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h0B,
                  a, $urandom_range(1, 4));
      end
      read_txn(1, 8'h03, a, 1);

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
